// File: rtl/ens_vote_argmax.sv
// Ensemble vote accumulator with serial argmax: sums N_ENS member score vectors per
// class, then scans one class per cycle for the highest total (lowest index on ties).
module ens_vote_argmax #(
    parameter int N_CLASSES = 10,
    parameter int N_ENS     = 4,
    parameter int SCORE_W   = 2,
    localparam int ACC_W    = SCORE_W + $clog2(N_ENS),
    localparam int IDX_W    = $clog2(N_CLASSES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [N_CLASSES*SCORE_W-1:0] s_scores,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [IDX_W-1:0]             m_class,
    output logic [ACC_W-1:0]             m_score
);

    localparam int CNT_W = (N_ENS > 1) ? $clog2(N_ENS) : 1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  best_idx;
    logic [ACC_W-1:0]  best_val;
    logic [ACC_W-1:0]  acc [N_CLASSES];
    logic              accept;
    logic              last_beat;
    logic              last_class;

    function automatic logic [ACC_W-1:0] score_of(
        input logic [N_CLASSES*SCORE_W-1:0] v,
        input int                           c
    );
        return ACC_W'(v[c*SCORE_W +: SCORE_W]);
    endfunction

    assign accept     = s_valid && s_ready;
    assign last_beat  = (cnt == CNT_W'(N_ENS - 1));
    assign last_class = (scan_idx == IDX_W'(N_CLASSES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    // s_ready depends only on state, never on m_ready, so a held result cannot be lost
    always_comb begin
        state_n = state;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_class = '0;
        m_score = '0;
        case (state)
            ACCUM: begin
                s_ready = 1'b1;
                if (accept && last_beat) state_n = SCAN;
            end
            SCAN: begin
                if (last_class) state_n = HOLD;
            end
            HOLD: begin
                m_valid = 1'b1;
                m_class = best_idx;
                m_score = best_val;
                if (m_ready) state_n = ACCUM;
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            scan_idx <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else begin
            if (accept) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end
            if (state == SCAN) begin
                if (scan_idx == '0 || acc[scan_idx] > best_val) begin
                    best_idx <= scan_idx;
                    best_val <= acc[scan_idx];
                end
                scan_idx <= last_class ? '0 : scan_idx + IDX_W'(1);
            end
        end
    end

    // First beat of a frame overwrites the totals, so no clear cycle and no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                acc[c] <= ((cnt == '0) ? '0 : acc[c]) + score_of(s_scores, c);
            end
        end
    end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Scoreboard bench for ens_vote_argmax: directed frames with hand-computed results,
// then randomized frames with gaps and output stalls checked against a small model.
module tb_ens_vote_argmax;

    localparam int NC = 10;
    localparam int NE = 4;
    localparam int SW = 2;
    localparam int AW = SW + $clog2(NE);
    localparam int IW = $clog2(NC);

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [NC*SW-1:0]  s_scores;
    logic              m_valid;
    logic              m_ready;
    logic [IW-1:0]     m_class;
    logic [AW-1:0]     m_score;

    ens_vote_argmax #(.N_CLASSES(NC), .N_ENS(NE), .SCORE_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_scores (s_scores),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
        .m_score  (m_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int score;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    int   mode     = 0;   // 0: m_ready=1, 1: random, 2: m_ready=0

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*SW-1:0] mk(input int base, input int ci, input int cv,
                                            input int cj, input int cjv);
        logic [NC*SW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*SW +: SW] = SW'(base);
        v[ci*SW +: SW] = SW'(cv);
        v[cj*SW +: SW] = SW'(cjv);
        return v;
    endfunction

    task automatic push_exp(input int cls, input int score);
        exp_t e;
        e.cls   = cls;
        e.score = score;
        q.push_back(e);
        n_pushed++;
    endtask

    // Called at posedge+#1; returns at posedge+#1 right after the accepting edge
    task automatic send_beat(input logic [NC*SW-1:0] sc);
        int w;
        s_valid  = 1'b1;
        s_scores = sc;
        w = 0;
        @(negedge clk);
        while (!s_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on each output handshake, checks hold stability and s_ready blocking
    initial begin
        logic          prev_hold = 1'b0;
        logic [IW-1:0] prev_cls  = '0;
        logic [AW-1:0] prev_sc   = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("s_ready_low_in_hold", int'(s_ready), 0);
                if (prev_hold) begin
                    chk("hold_class_stable", int'(m_class), int'(prev_cls));
                    chk("hold_score_stable", int'(m_score), int'(prev_sc));
                end
                if (m_ready && !rst) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        n_popped++;
                        chk("m_class", int'(m_class), e.cls);
                        chk("m_score", int'(m_score), e.score);
                    end
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_cls  = m_class;
            prev_sc   = m_score;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            k;
        int            sum [NC];
        int            bi;
        int            bv;
        logic [NC*SW-1:0] v;

        rst      = 1'b1;
        s_valid  = 1'b0;
        s_scores = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_s_ready", int'(s_ready), 1);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_class", int'(m_class), 0);
        chk("reset_m_score", int'(m_score), 0);
        @(posedge clk);
        #1;

        // Class 3 dominates; also measure latency from final beat to m_valid
        mode = 0;
        for (int b = 0; b < NE; b++) begin
            if (b == NE - 1) push_exp(3, 12);
            send_beat(mk(1, 3, 3, 3, 3));
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_valid && k < 50);
        chk("latency", k, 11);
        drain();

        // Tie between classes 2 and 7, with idle gaps between beats
        for (int b = 0; b < NE; b++) begin
            if (b == NE - 1) push_exp(2, 8);
            idle(b);
            send_beat(mk(1, 2, 2, 7, 2));
        end
        drain();

        // All zeros
        for (int b = 0; b < NE; b++) begin
            if (b == NE - 1) push_exp(0, 0);
            send_beat(mk(0, 0, 0, 0, 0));
        end
        drain();

        // Stall the result for 20 cycles while the next frame is offered
        mode = 2;
        for (int b = 0; b < NE; b++) begin
            if (b == NE - 1) push_exp(5, 12);
            send_beat(mk(0, 5, 3, 5, 3));
        end
        s_valid  = 1'b1;
        s_scores = mk(0, 8, 3, 0, 2);
        k = 0;
        while (!m_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("hold_reached", int'(m_valid), 1);
        repeat (20) begin
            @(negedge clk);
            chk("stall_m_valid", int'(m_valid), 1);
            chk("stall_s_ready", int'(s_ready), 0);
        end
        @(posedge clk);
        #1;
        mode = 0;
        for (int b = 0; b < NE; b++) begin
            if (b == NE - 1) push_exp(8, 12);
            send_beat(mk(0, 8, 3, 0, 2));
        end
        drain();

        // Reset mid-frame discards the first two beats
        send_beat(mk(0, 9, 3, 9, 3));
        send_beat(mk(0, 9, 3, 9, 3));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
        for (int b = 0; b < NE; b++) begin
            if (b == NE - 1) push_exp(9, 8);
            send_beat(mk(0, 9, 2, 9, 2));
        end
        drain();

        // Randomized frames with input gaps and output stalls against a reference model
        mode = 1;
        for (int f = 0; f < 1000; f++) begin
            for (int c = 0; c < NC; c++) sum[c] = 0;
            for (int b = 0; b < NE; b++) begin
                for (int c = 0; c < NC; c++) begin
                    v[c*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
                    sum[c] += int'(v[c*SW +: SW]);
                end
                if (b == NE - 1) begin
                    bi = 0;
                    bv = sum[0];
                    for (int c = 1; c < NC; c++) begin
                        if (sum[c] > bv) begin
                            bi = c;
                            bv = sum[c];
                        end
                    end
                    push_exp(bi, bv);
                end
                idle($urandom_range(0, 2));
                send_beat(v);
            end
        end
        mode = 0;
        drain();
        chk("results_count", n_popped, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
